// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// Inter-stage pipeline register for the OpenMIPS core. One instance can sit
// on any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES
// independent payload lanes, each with its own valid bit, and obeys the
// global stall vector. It has a synchronous flush for branch and exception
// recovery. When this stage stops but the downstream stage keeps running,
// the register inserts a bubble so the downstream stage sees a nop.
//
// Each cycle exactly one action is taken, in this priority order:
//    RESET  > FLUSH > BUBBLE (hold & !next_stop) > LOAD (!hold) > KEEP
//
// Optional feature: define PIPE_STAGE_REG_CNT_EN to add the saturating
// bubble and hold performance counters and the cnt_clr input.
//
// Parameters:
//    DATA_W   payload width per lane
//    LANES    number of parallel lanes
//    STAGE    this register's own bit in stall; STAGE+1 is the downstream bit
//    STALL_W  stall vector width
//    CNT_W    counter width (only meaningful with PIPE_STAGE_REG_CNT_EN)
//
// Ports:
//    clk         clock, rising edge
//    rst         synchronous active-high reset
//    stall       global stall vector, 1 = stop
//    flush       synchronous kill of all lanes
//    in_valid    per-lane valid from the upstream stage
//    in_data     payload; lane i occupies [i*DATA_W +: DATA_W]
//    out_valid   registered per-lane valid
//    out_data    registered payload (invalid lanes always carry zero)
//    cnt_clr     synchronous counter clear          (macro only)
//    bubble_cnt  number of BUBBLE cycles, saturating (macro only)
//    hold_cnt    number of KEEP cycles, saturating   (macro only)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W  = 64,
   parameter int LANES   = 1,
   parameter int STAGE   = 1,
   parameter int STALL_W = 6,
   parameter int CNT_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [STALL_W-1:0]        stall,
   input  logic                      flush,
   input  logic [LANES-1:0]          in_valid,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic [LANES-1:0]          out_valid,
   output logic [LANES*DATA_W-1:0]   out_data
`ifdef PIPE_STAGE_REG_CNT_EN
   ,
   input  logic                      cnt_clr,
   output logic [CNT_W-1:0]          bubble_cnt,
   output logic [CNT_W-1:0]          hold_cnt
`endif
);

   // The action chosen for the current cycle.
   typedef enum logic [2:0] {
      ACT_RESET,
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_LOAD,
      ACT_KEEP
   } action_t;

   // Reject parameter combinations that would index outside the stall
   // vector or produce a zero-width counter.
   generate
      if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
         $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
      end
      if (CNT_W < 1) begin : g_bad_cnt
         $error("pipe_stage_reg: CNT_W must be at least 1");
      end
   endgenerate

   logic    hold;
   logic    next_stop;
   action_t action;
   logic [LANES*DATA_W-1:0] load_data;

   // Only our own stall bit and the downstream one matter; all other stall
   // bits are deliberately ignored.
   logic    unused_stall;
   assign unused_stall = ^stall;

   assign hold      = stall[STAGE];
   assign next_stop = stall[STAGE+1];

   // Pick this cycle's action. hold=0 with next_stop=1 is an upstream
   // controller error, but it still loads so the pipeline never wedges.
   always_comb begin
      action = ACT_KEEP;
      if (rst) begin
         action = ACT_RESET;
      end else if (flush) begin
         action = ACT_FLUSH;
      end else if (hold && !next_stop) begin
         action = ACT_BUBBLE;
      end else if (!hold) begin
         action = ACT_LOAD;
      end else begin
         action = ACT_KEEP;
      end
   end

   // Mask the payload of invalid lanes to zero so a dead lane never leaks
   // stale data downstream.
   always_comb begin
      load_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_valid[i]) begin
            load_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // The register itself. RESET, FLUSH and BUBBLE all produce the all-zero
   // nop word, and KEEP leaves the contents untouched.
   always_ff @(posedge clk) begin
      unique case (action)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            out_valid <= '0;
            out_data  <= '0;
         end
         ACT_LOAD: begin
            out_valid <= in_valid;
            out_data  <= load_data;
         end
         ACT_KEEP: begin
            out_valid <= out_valid;
            out_data  <= out_data;
         end
         default: begin
            out_valid <= '0;
            out_data  <= '0;
         end
      endcase
   end

`ifdef PIPE_STAGE_REG_CNT_EN
   // Performance counters. They saturate at all-ones instead of wrapping.
   // Clearing beats incrementing. Flush cycles are not counted, and a flush
   // does not otherwise disturb the counters.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         bubble_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         if (action == ACT_BUBBLE && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
         if (action == ACT_KEEP && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
